// File: rtl/ucsbece154b_hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline.
// Drives per-stage stall/flush controls and the Execute-stage forwarding
// selects. Hazard sources, highest priority first: reset, data-memory wait,
// multi-cycle multiply occupancy, branch mispredict, load-use.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall-cycle and
// mispredict performance counters; when undefined both outputs are tied to 0.
//
// Multiply FSM states:
//   state | meaning
//   IDLE  | no multi-cycle multiply in progress (first Execute cycle of a mul)
//   BUSY  | multiply occupying Execute; cnt counts down remaining cycles
module ucsbece154b_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D_i,
    input  logic [REG_AW-1:0] Rs2D_i,
    input  logic [REG_AW-1:0] Rs1E_i,
    input  logic [REG_AW-1:0] Rs2E_i,
    input  logic [REG_AW-1:0] RdE_i,
    input  logic [REG_AW-1:0] RdM_i,
    input  logic [REG_AW-1:0] RdW_i,
    input  logic              RegWriteM_i,
    input  logic              RegWriteW_i,
    input  logic [1:0]        ResultSrcE_i,
    input  logic              MulE_i,
    input  logic              PCSrcE_i,
    input  logic              BranchTakenE_i,
    input  logic              MemReqM_i,
    input  logic              DMemReadyM_i,
    output logic              StallF_o,
    output logic              StallD_o,
    output logic              StallE_o,
    output logic              StallM_o,
    output logic              StallW_o,
    output logic              FlushD_o,
    output logic              FlushE_o,
    output logic              FlushM_o,
    output logic [1:0]        ForwardAE_o,
    output logic [1:0]        ForwardBE_o,
    output logic              MulBusy_o,
    output logic [CNT_W-1:0]  StallCycles_o,
    output logic [CNT_W-1:0]  MispredCount_o
);

    // Counter is wide enough to hold MUL_LAT-1; with MUL_LAT=1 the FSM is inert.
    localparam int            CW        = $clog2(MUL_LAT) + 1;
    localparam bit            MUL_MULTI = (MUL_LAT > 1);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mulState_t;

    mulState_t     state, stateNext;
    logic [CW-1:0] cnt, cntNext;

    logic memStall;
    logic mispred;
    logic lwStall;
    logic mulStall;

    assign memStall = MemReqM_i & ~DMemReadyM_i;
    assign mispred  = (PCSrcE_i != BranchTakenE_i);
    assign lwStall  = (ResultSrcE_i == 2'b01) &
                      ((Rs1D_i == RdE_i) | (Rs2D_i == RdE_i)) &
                      (RdE_i != '0);
    // The last Execute cycle of a multiply (BUSY, cnt==1) releases the stall.
    assign mulStall = MUL_MULTI & MulE_i &
                      ((state == IDLE) | ((state == BUSY) & (cnt != CNT_ONE)));

    // Multiply FSM state register; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Multiply FSM next state; a memory wait freezes the whole FSM.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (!memStall) begin
            case (state)
                IDLE: begin
                    if (MulE_i && MUL_MULTI) begin
                        stateNext = BUSY;
                        cntNext   = CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_ONE) stateNext = IDLE;
                    else                cntNext   = cnt - CNT_ONE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign MulBusy_o = (state == BUSY);

    // Prioritised stall/flush selection; exactly one hazard source acts per cycle.
    always_comb begin
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        StallW_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        FlushM_o = 1'b0;
        if (reset) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
            FlushM_o = 1'b1;
        end else if (memStall) begin
            // E stays frozen, so a pending mispredict is still visible afterwards.
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            StallW_o = 1'b1;
        end else if (mulStall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            FlushM_o = 1'b1;
        end else if (mispred) begin
            // No F/D stall here, otherwise the redirected fetch would be lost.
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
        end else if (lwStall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
        end
    end

    // Execute operand forwarding; the younger M result wins over W.
    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        if (RegWriteM_i && (RdM_i == Rs1E_i) && (Rs1E_i != '0))      ForwardAE_o = 2'b10;
        else if (RegWriteW_i && (RdW_i == Rs1E_i) && (Rs1E_i != '0)) ForwardAE_o = 2'b01;
        if (RegWriteM_i && (RdM_i == Rs2E_i) && (Rs2E_i != '0))      ForwardBE_o = 2'b10;
        else if (RegWriteW_i && (RdW_i == Rs2E_i) && (Rs2E_i != '0)) ForwardBE_o = 2'b01;
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] mispredCount;
    logic             mispredApplied;

    assign mispredApplied = ~reset & ~memStall & ~mulStall & mispred;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCycles  <= '0;
            mispredCount <= '0;
        end else begin
            if (StallF_o && (stallCycles != '1))
                stallCycles <= stallCycles + CNT_INC;
            if (mispredApplied && (mispredCount != '1))
                mispredCount <= mispredCount + CNT_INC;
        end
    end

    assign StallCycles_o  = stallCycles;
    assign MispredCount_o = mispredCount;
`else
    assign StallCycles_o  = '0;
    assign MispredCount_o = '0;
`endif

endmodule

// File: tb/tb_ucsbece154b_hazard_ctrl.sv
// Directed bench for ucsbece154b_hazard_ctrl (default parameters, MUL_LAT=3).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_ucsbece154b_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
    logic        RegWriteM_i, RegWriteW_i;
    logic [1:0]  ResultSrcE_i;
    logic        MulE_i, PCSrcE_i, BranchTakenE_i, MemReqM_i, DMemReadyM_i;
    logic        StallF_o, StallD_o, StallE_o, StallM_o, StallW_o;
    logic        FlushD_o, FlushE_o, FlushM_o;
    logic [1:0]  ForwardAE_o, ForwardBE_o;
    logic        MulBusy_o;
    logic [31:0] StallCycles_o, MispredCount_o;

    int checks = 0;
    int errors = 0;

    ucsbece154b_hazard_ctrl #(.REG_AW(5), .MUL_LAT(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
        .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i),
        .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
        .ResultSrcE_i(ResultSrcE_i), .MulE_i(MulE_i), .PCSrcE_i(PCSrcE_i),
        .BranchTakenE_i(BranchTakenE_i), .MemReqM_i(MemReqM_i), .DMemReadyM_i(DMemReadyM_i),
        .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o),
        .StallM_o(StallM_o), .StallW_o(StallW_o),
        .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushM_o(FlushM_o),
        .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
        .MulBusy_o(MulBusy_o),
        .StallCycles_o(StallCycles_o), .MispredCount_o(MispredCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // stall = {F,D,E,M,W}, flush = {D,E,M}
    typedef struct {
        string      name;
        logic [4:0] rs1D, rs2D, rdE;
        logic [1:0] resSrc;
        logic       pcSrc, bt, memReq, ready;
        logic [4:0] rs1E, rs2E, rdM, rdW;
        logic       rwM, rwW;
        logic [4:0] expStall;
        logic [2:0] expFlush;
        logic [1:0] expFA, expFB;
    } vec_t;

    vec_t vq[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        Rs1D_i = '0; Rs2D_i = '0; Rs1E_i = '0; Rs2E_i = '0;
        RdE_i = '0; RdM_i = '0; RdW_i = '0;
        RegWriteM_i = 1'b0; RegWriteW_i = 1'b0; ResultSrcE_i = 2'b00;
        MulE_i = 1'b0; PCSrcE_i = 1'b0; BranchTakenE_i = 1'b0;
        MemReqM_i = 1'b0; DMemReadyM_i = 1'b1;
    endtask

    task automatic checkAll(input string nm, input logic [4:0] es, input logic [2:0] ef,
                            input logic [1:0] efa, input logic [1:0] efb, input logic eb);
        @(negedge clk);
        cmp({nm, "_stall"}, 32'({StallF_o, StallD_o, StallE_o, StallM_o, StallW_o}), 32'(es));
        cmp({nm, "_flush"}, 32'({FlushD_o, FlushE_o, FlushM_o}), 32'(ef));
        cmp({nm, "_fwd"},   32'({ForwardAE_o, ForwardBE_o}), 32'({efa, efb}));
        cmp({nm, "_busy"},  32'(MulBusy_o), 32'(eb));
    endtask

    initial begin
        // name, rs1D, rs2D, rdE, resSrc, pcSrc, bt, memReq, ready, rs1E, rs2E, rdM, rdW, rwM, rwW, stall, flush, fa, fb
        vq.push_back(vec_t'{"idle_x0",     0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 5'b00000, 3'b000, 2'b00, 2'b00});
        vq.push_back(vec_t'{"lw_rs1",      5, 0, 5, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b11000, 3'b010, 2'b00, 2'b00});
        vq.push_back(vec_t'{"lw_rs2",      3, 5, 5, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b11000, 3'b010, 2'b00, 2'b00});
        vq.push_back(vec_t'{"lw_rd0",      0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 3'b000, 2'b00, 2'b00});
        vq.push_back(vec_t'{"alu_nohaz",   5, 0, 5, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 3'b000, 2'b00, 2'b00});
        vq.push_back(vec_t'{"lw_nomatch",  4, 6, 5, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 3'b000, 2'b00, 2'b00});
        vq.push_back(vec_t'{"mispred_nt",  0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 3'b110, 2'b00, 2'b00});
        vq.push_back(vec_t'{"mispred_t",   0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 3'b110, 2'b00, 2'b00});
        vq.push_back(vec_t'{"mispred_lw",  5, 0, 5, 2'b01, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 3'b110, 2'b00, 2'b00});
        vq.push_back(vec_t'{"pred_ok_lw",  5, 0, 5, 2'b01, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b11000, 3'b010, 2'b00, 2'b00});
        vq.push_back(vec_t'{"memstall",    5, 0, 5, 2'b01, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00});
        vq.push_back(vec_t'{"mem_ready",   5, 0, 5, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5'b11000, 3'b010, 2'b00, 2'b00});
        vq.push_back(vec_t'{"mem_noreq",   0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3'b000, 2'b00, 2'b00});
        vq.push_back(vec_t'{"fwd_m_over_w",0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 7, 7, 7, 1, 1, 5'b00000, 3'b000, 2'b00, 2'b10});
        vq.push_back(vec_t'{"fwd_rs_x0",   0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 7, 7, 1, 1, 5'b00000, 3'b000, 2'b00, 2'b00});
        vq.push_back(vec_t'{"fwd_w_only",  0, 0, 0, 2'b00, 0, 0, 0, 1, 3, 7, 3, 7, 1, 1, 5'b00000, 3'b000, 2'b10, 2'b01});
        vq.push_back(vec_t'{"fwd_m_off",   0, 0, 0, 2'b00, 0, 0, 0, 1, 7, 7, 7, 7, 0, 1, 5'b00000, 3'b000, 2'b01, 2'b01});
        vq.push_back(vec_t'{"fwd_none",    0, 0, 0, 2'b00, 0, 0, 0, 1, 7, 9, 7, 9, 0, 0, 5'b00000, 3'b000, 2'b00, 2'b00});
        vq.push_back(vec_t'{"fwd_in_mem",  0, 0, 0, 2'b00, 0, 0, 1, 0, 9, 4, 9, 4, 1, 1, 5'b11111, 3'b000, 2'b10, 2'b01});

        // Reset overrides every other hazard source.
        setIdle();
        reset = 1'b1;
        @(posedge clk);
        nextCycle();
        Rs1D_i = 5; RdE_i = 5; ResultSrcE_i = 2'b01; PCSrcE_i = 1'b1; MemReqM_i = 1'b1; DMemReadyM_i = 1'b0;
        checkAll("reset", 5'b00000, 3'b111, 2'b00, 2'b00, 1'b0);
        cmp("reset_stallcnt", StallCycles_o, 32'd0);
        cmp("reset_mispcnt", MispredCount_o, 32'd0);

        nextCycle();
        reset = 1'b0;
        foreach (vq[i]) begin
            if (i > 0) nextCycle();
            setIdle();
            Rs1D_i = vq[i].rs1D; Rs2D_i = vq[i].rs2D; RdE_i = vq[i].rdE; ResultSrcE_i = vq[i].resSrc;
            PCSrcE_i = vq[i].pcSrc; BranchTakenE_i = vq[i].bt;
            MemReqM_i = vq[i].memReq; DMemReadyM_i = vq[i].ready;
            Rs1E_i = vq[i].rs1E; Rs2E_i = vq[i].rs2E; RdM_i = vq[i].rdM; RdW_i = vq[i].rdW;
            RegWriteM_i = vq[i].rwM; RegWriteW_i = vq[i].rwW;
            checkAll(vq[i].name, vq[i].expStall, vq[i].expFlush, vq[i].expFA, vq[i].expFB, 1'b0);
        end

        // Load-use: one stall cycle, then the load result forwards from W.
        nextCycle(); setIdle(); RdE_i = 5; ResultSrcE_i = 2'b01; Rs1D_i = 5;
        checkAll("lu_c1", 5'b11000, 3'b010, 2'b00, 2'b00, 1'b0);
        nextCycle(); setIdle(); Rs1E_i = 5; RdW_i = 5; RegWriteW_i = 1'b1;
        checkAll("lu_c2", 5'b00000, 3'b000, 2'b01, 2'b00, 1'b0);

        // Multiply held in Execute for 3 cycles.
        nextCycle(); setIdle(); MulE_i = 1'b1;
        checkAll("mul_c1", 5'b11100, 3'b001, 2'b00, 2'b00, 1'b0);
        nextCycle();
        checkAll("mul_c2", 5'b11100, 3'b001, 2'b00, 2'b00, 1'b1);
        nextCycle();
        checkAll("mul_c3", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1);
        nextCycle(); MulE_i = 1'b0;
        checkAll("mul_done", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Memory wait hides a mispredict until the data arrives.
        nextCycle(); setIdle(); MemReqM_i = 1'b1; DMemReadyM_i = 1'b0; PCSrcE_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nextCycle();
            checkAll("memwait", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
        end
        nextCycle(); DMemReadyM_i = 1'b1;
        checkAll("memwait_rel", 5'b00000, 3'b110, 2'b00, 2'b00, 1'b0);

        // Memory wait freezes the multiply FSM, both in IDLE and in BUSY.
        nextCycle(); setIdle(); MulE_i = 1'b1; MemReqM_i = 1'b1; DMemReadyM_i = 1'b0;
        checkAll("mulmem_idle", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
        nextCycle(); DMemReadyM_i = 1'b1;
        checkAll("mulmem_start", 5'b11100, 3'b001, 2'b00, 2'b00, 1'b0);
        nextCycle(); DMemReadyM_i = 1'b0;
        checkAll("mulmem_frz1", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b1);
        nextCycle();
        checkAll("mulmem_frz2", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b1);
        nextCycle(); DMemReadyM_i = 1'b1;
        checkAll("mulmem_resume", 5'b11100, 3'b001, 2'b00, 2'b00, 1'b1);
        nextCycle();
        checkAll("mulmem_last", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1);
        nextCycle(); setIdle();
        checkAll("mulmem_done", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Reset during a multiply aborts it.
        nextCycle(); setIdle(); MulE_i = 1'b1;
        checkAll("rstmul_c1", 5'b11100, 3'b001, 2'b00, 2'b00, 1'b0);
        nextCycle(); reset = 1'b1;
        checkAll("rstmul_rst", 5'b00000, 3'b111, 2'b00, 2'b00, 1'b1);
        nextCycle(); reset = 1'b0;
        checkAll("rstmul_after", 5'b11100, 3'b001, 2'b00, 2'b00, 1'b0);
        nextCycle(); setIdle();
        repeat (3) nextCycle();

        // Performance counters: 3 applied mispredicts, 3 StallF cycles.
        reset = 1'b1;
        nextCycle(); reset = 1'b0; PCSrcE_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) nextCycle();
            checkAll("cnt_misp", 5'b00000, 3'b110, 2'b00, 2'b00, 1'b0);
        end
        nextCycle(); setIdle(); Rs1D_i = 5; RdE_i = 5; ResultSrcE_i = 2'b01;
        checkAll("cnt_lw1", 5'b11000, 3'b010, 2'b00, 2'b00, 1'b0);
        nextCycle();
        checkAll("cnt_lw2", 5'b11000, 3'b010, 2'b00, 2'b00, 1'b0);
        nextCycle(); setIdle(); MemReqM_i = 1'b1; DMemReadyM_i = 1'b0; PCSrcE_i = 1'b1;
        checkAll("cnt_mem", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
        nextCycle(); setIdle();
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        cmp("cnt_mispred", MispredCount_o, 32'd3);
        cmp("cnt_stall", StallCycles_o, 32'd3);
`else
        cmp("cnt_mispred_off", MispredCount_o, 32'd0);
        cmp("cnt_stall_off", StallCycles_o, 32'd0);
`endif
        nextCycle(); reset = 1'b1;
        nextCycle(); reset = 1'b0;
        @(negedge clk);
        cmp("cnt_mispred_rst", MispredCount_o, 32'd0);
        cmp("cnt_stall_rst", StallCycles_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
